// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

  // Scan phases: all digits dark, or one digit lit.
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } seg7_state_t;

  localparam int         NIBBLE_W = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/seg7_dwell_timer.sv
// Dwell timer for the scan FSM: counts the current phase length and flags
// its last cycle. Phase length is SHOW_CYCLES in ST_SHOW, DEAD_CYCLES in
// ST_BLANK. The counter restarts at zero on every expire, so each phase
// lasts exactly its configured number of cycles.
module seg7_dwell_timer
  import seg7_pkg::*;
#(
  parameter int SHOW_CYCLES = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  seg7_state_t state,
  output logic        expire
);

  localparam int MAX_C = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;

  // Terminal count follows the phase being timed.
  always_comb begin
    last   = (state == ST_SHOW) ? SHOW_LAST : DEAD_LAST;
    expire = (cnt == last);
  end

  // Free-running phase counter, cleared at the end of each phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one BCD-to-7-segment decoder.
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero blanking).
//
// Load handshake: `load` is a one-cycle strobe with no ready; every cycle
// it is high, `digits_in` is captured into the shadow frame (latest wins).
// The shadow is committed to the displayed frame only at a frame wrap, or
// directly if the strobe coincides with the wrap.
//
// All outputs come from a register stage fed by the scan state, so each
// output change lags the internal state change by one clock.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
  input  logic                           load,
  output logic [NIBBLE_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic                           pending,
  output logic                           frame_done,
  output seg7_state_t                    state_dbg
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  seg7_state_t                    state;
  seg7_state_t                    state_nxt;
  logic [IDX_W-1:0]               idx;
  logic [NIBBLE_W*NUM_DIGITS-1:0] disp;
  logic [NIBBLE_W*NUM_DIGITS-1:0] shadow;
  logic                           pend_r;
  logic                           wrap_r;
  logic                           expire;
  logic                           wrap;
  logic [NIBBLE_W-1:0]            cur_nib;
  logic [NUM_DIGITS-1:0]          lz_mask;
  logic                           suppress;
  logic [NUM_DIGITS-1:0]          an_d;

  seg7_dwell_timer #(
    .SHOW_CYCLES (SHOW_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .state  (state),
    .expire (expire)
  );

  assign state_dbg = state;

  // Next-state logic; a wrap is the SHOW->BLANK step out of the last digit.
  always_comb begin
    state_nxt = state;
    wrap      = 1'b0;
    case (state)
      ST_BLANK: if (expire) state_nxt = ST_SHOW;
      ST_SHOW: begin
        if (expire) begin
          state_nxt = ST_BLANK;
          wrap      = (idx == IDX_LAST);
        end
      end
    endcase
  end

  // Scan state register and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_BLANK;
      idx    <= '0;
      wrap_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      wrap_r <= wrap;
      if (state == ST_SHOW && expire) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Frame registers: shadow always takes the strobe, disp only at a wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp   <= '0;
      shadow <= '0;
      pend_r <= 1'b0;
    end else begin
      if (load) shadow <= digits_in;
      if (wrap) begin
        if (load) begin
          disp   <= digits_in;
          pend_r <= 1'b0;
        end else if (pend_r) begin
          disp   <= shadow;
          pend_r <= 1'b0;
        end
      end else if (load) begin
        pend_r <= 1'b1;
      end
    end
  end

  assign cur_nib = disp[idx*NIBBLE_W +: NIBBLE_W];

`ifdef SEG7_LZ_BLANK_EN
  logic seen_nz;

  // Blank zeros from the top digit down until the first nonzero digit;
  // digit 0 always shows.
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (!seen_nz && disp[i*NIBBLE_W +: NIBBLE_W] == 4'd0) begin
        lz_mask[i] = 1'b1;
      end else begin
        seen_nz = 1'b1;
      end
    end
  end
`else
  // Zeros display normally.
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Anode pattern: only the current digit, only in SHOW, only if displayable.
  always_comb begin
    suppress = (cur_nib > BCD_MAX) || lz_mask[idx];
    an_d     = '1;
    if (state == ST_SHOW && !suppress) an_d[idx] = 1'b0;
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_out    <= '0;
      an_n       <= '1;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bcd_out    <= cur_nib;
      an_n       <= an_d;
      pending    <= pend_r;
      frame_done <= wrap_r;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, SHOW=8, DEAD=2).
// A timeline model derives every expected output from the cycle number
// since reset; expectations are queued at each edge and compared on the
// following falling edge.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int N     = 4;
  localparam int S     = 8;
  localparam int D     = 2;
  localparam int SLOT  = D + S;
  localparam int FRAME = N * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        pending;
  logic        frame_done;
  seg7_state_t state_dbg;

  int          total = 0;
  int          bad   = 0;
  int          k     = -1;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic [9:0]  exp_q[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SHOW_CYCLES (S),
    .DEAD_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_in  (digits_in),
    .load       (load),
    .bcd_out    (bcd_out),
    .an_n       (an_n),
    .pending    (pending),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] f, input int i);
    return f[i*4 +: 4];
  endfunction

  // Leading-zero suppression: digits above the highest nonzero digit.
  function automatic logic lz_sup(input logic [15:0] f, input int i);
`ifdef SEG7_LZ_BLANK_EN
    int h;
    h = 0;
    for (int j = 0; j < N; j++) if (nib(f, j) != 4'd0) h = j;
    return i > h;
`else
    return (f[0] & 1'b0) | (i < 0);
`endif
  endfunction

  // Model: expected output after each edge, then frame-register update.
  always @(posedge clk) begin
    if (!rst_n) begin
      k        = -1;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      exp_q.push_back({4'hF, 4'h0, 1'b0, 1'b0});
    end else begin
      int p;
      int i;
      int r;
      logic [3:0] e_an;
      logic [3:0] e_bcd;
      k++;
      p     = k % FRAME;
      i     = p / SLOT;
      r     = p % SLOT;
      e_bcd = nib(m_disp, i);
      e_an  = 4'hF;
      if (r >= D && e_bcd <= 4'd9 && !lz_sup(m_disp, i)) e_an[i] = 1'b0;
      exp_q.push_back({e_an, e_bcd, m_pend, (p == 0 && k >= FRAME)});
      if (p == FRAME - 1) begin
        if (load) begin
          m_disp = digits_in;
          m_pend = 1'b0;
        end else if (m_pend) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) m_shadow = digits_in;
    end
  end

  // Scoreboard: compare the DUT against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      check("an_n",       16'(an_n),       16'(e[9:6]));
      check("bcd_out",    16'(bcd_out),    16'(e[5:2]));
      check("pending",    16'(pending),    16'(e[1]));
      check("frame_done", 16'(frame_done), 16'(e[0]));
    end
  end

  // Wait until the falling edge after edge kk.
  task automatic wait_k(input int kk);
    while (k < kk) @(negedge clk);
  endtask

  // Pulse load so that it is sampled on edge kk.
  task automatic load_at(input int kk, input logic [15:0] v);
    wait_k(kk - 1);
    digits_in = v;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    digits_in = 16'($urandom_range(0, 65535));
  endtask

  // Stimulus.
  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_at(5, 16'h1234);
    load_at(50, 16'h1111);
    load_at(60, 16'h5678);
    load_at(FRAME * 3 - 1, 16'h9876);
    load_at(130, 16'h3A12);
    load_at(170, 16'h0070);
    load_at(FRAME * 5 + 5, 16'h0A60);
    wait_k(FRAME * 6 + 2 * SLOT + D + 1);
    rst_n     = 1'b0;
    load      = 1'b1;
    digits_in = 16'h7777;
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    load_at(20, 16'h4321);
    wait_k(FRAME * 2 + 10);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog k=%0d got=timeout want=finish", k);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
